// File: rtl/axis_packet_receiver.sv
// Store-and-forward AXI-Stream packet receiver: validates first/last/dest framing,
// buffers each packet speculatively, commits on a clean TLAST and replays committed packets.
`timescale 1ns/1ps
module axis_packet_receiver #(
    parameter int DEPTH = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_tvalid,
    output logic             s_tready,
    input  logic [31:0]      s_tdata,
    input  logic             s_tlast,
    input  logic [7:0]       s_tdest,
    input  logic [3:0]       s_tuser,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic [31:0]      m_tdata,
    output logic             m_tlast,
    output logic [7:0]       m_tdest,
    output logic [3:0]       err_pulse,
    output logic [CNT_W-1:0] pkt_ok_cnt,
    output logic [CNT_W-1:0] pkt_err_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE = 2'd0, BODY = 2'd1, DROP = 2'd2} state_t;

    function automatic logic is_full(input logic [AW:0] w, input logic [AW:0] r);
        return (w[AW] != r[AW]) && (w[AW-1:0] == r[AW-1:0]);
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt, input logic [1:0] inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, cnt} + {{(CNT_W-1){1'b0}}, inc};
        if (sum[CNT_W]) begin
            return {CNT_W{1'b1}};
        end else begin
            return sum[CNT_W-1:0];
        end
    endfunction

    // entry layout: {tlast, tdest, tdata}
    logic [40:0]      mem_r [DEPTH];
    state_t           state_r, state_n;
    logic [AW:0]      wr_r, wr_n, commit_r, commit_n, rd_r, rd_n;
    logic [7:0]       dest_r, dest_n;
    logic             s_tready_r, m_tvalid_r, m_tlast_r;
    logic [31:0]      m_tdata_r;
    logic [7:0]       m_tdest_r;
    logic [3:0]       err_pulse_r, err_s;
    logic [CNT_W-1:0] pkt_ok_cnt_r, pkt_err_cnt_r;
    logic             accept_s, full_s, we_s, first_s, ok_inc_s, pop_s, valid_n_s;
    logic [1:0]       err_inc_s;
    logic [AW-1:0]    waddr_s;
    logic [40:0]      rd_word_s;
    logic             unused_s;

    assign unused_s = ^s_tuser[3:1];
    assign accept_s = s_tvalid & s_tready_r;
    assign full_s   = is_full(wr_r, rd_r);

    // Framing FSM: next state, speculative pointer updates, error flags and buffer write.
    always_comb begin
        state_n   = state_r;
        wr_n      = wr_r;
        commit_n  = commit_r;
        dest_n    = dest_r;
        we_s      = 1'b0;
        waddr_s   = wr_r[AW-1:0];
        err_s     = 4'b0000;
        err_inc_s = 2'd0;
        ok_inc_s  = 1'b0;
        first_s   = 1'b0;
        if (accept_s) begin
            case (state_r)
                IDLE: first_s = 1'b1;
                BODY: begin
                    if (s_tuser[0]) begin
                        err_s[1]  = 1'b1;
                        err_inc_s = 2'd1;
                        wr_n      = commit_r;
                        first_s   = 1'b1;
                    end else if (s_tdest != dest_r) begin
                        err_s[2]  = 1'b1;
                        err_inc_s = 2'd1;
                        wr_n      = commit_r;
                        state_n   = s_tlast ? IDLE : DROP;
                    end else if (full_s) begin
                        err_s[3]  = 1'b1;
                        err_inc_s = 2'd1;
                        wr_n      = commit_r;
                        state_n   = s_tlast ? IDLE : DROP;
                    end else begin
                        we_s    = 1'b1;
                        waddr_s = wr_r[AW-1:0];
                        wr_n    = wr_r + PTR_ONE;
                        if (s_tlast) begin
                            commit_n = wr_r + PTR_ONE;
                            ok_inc_s = 1'b1;
                            state_n  = IDLE;
                        end else begin
                            state_n = BODY;
                        end
                    end
                end
                DROP: begin
                    if (s_tlast) begin
                        state_n = IDLE;
                    end else begin
                        state_n = DROP;
                    end
                end
                default: state_n = IDLE;
            endcase
            // a first beat always starts from the committed pointer (wr==commit outside BODY)
            if (first_s) begin
                if (!s_tuser[0]) begin
                    err_s[0]  = 1'b1;
                    err_inc_s = err_inc_s + 2'd1;
                    wr_n      = commit_r;
                    state_n   = s_tlast ? IDLE : DROP;
                end else if (s_tdest != s_tdata[31:24]) begin
                    err_s[2]  = 1'b1;
                    err_inc_s = err_inc_s + 2'd1;
                    wr_n      = commit_r;
                    state_n   = s_tlast ? IDLE : DROP;
                end else begin
                    we_s    = 1'b1;
                    waddr_s = commit_r[AW-1:0];
                    wr_n    = commit_r + PTR_ONE;
                    dest_n  = s_tdest;
                    if (s_tlast) begin
                        commit_n = commit_r + PTR_ONE;
                        ok_inc_s = 1'b1;
                        state_n  = IDLE;
                    end else begin
                        state_n = BODY;
                    end
                end
            end else begin
                first_s = 1'b0;
            end
        end else begin
            state_n = state_r;
        end
    end

    // Output side: the slot at rd stays owned by the output register until popped.
    always_comb begin
        pop_s     = m_tvalid_r & m_tready;
        rd_n      = pop_s ? (rd_r + PTR_ONE) : rd_r;
        valid_n_s = (rd_n != commit_r);
        rd_word_s = mem_r[rd_n[AW-1:0]];
    end

    // Packet buffer storage.
    always_ff @(posedge clk) begin
        if (we_s) begin
            mem_r[waddr_s] <= {s_tlast, s_tdest, s_tdata};
        end
    end

    // Control state, pointers, flags, counters and the registered stream outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            wr_r          <= '0;
            commit_r      <= '0;
            rd_r          <= '0;
            dest_r        <= 8'h00;
            s_tready_r    <= 1'b0;
            m_tvalid_r    <= 1'b0;
            m_tdata_r     <= 32'h0000_0000;
            m_tlast_r     <= 1'b0;
            m_tdest_r     <= 8'h00;
            err_pulse_r   <= 4'b0000;
            pkt_ok_cnt_r  <= '0;
            pkt_err_cnt_r <= '0;
        end else begin
            state_r       <= state_n;
            wr_r          <= wr_n;
            commit_r      <= commit_n;
            rd_r          <= rd_n;
            dest_r        <= dest_n;
            s_tready_r    <= ~(is_full(wr_n, rd_n) & (commit_n != rd_n));
            m_tvalid_r    <= valid_n_s;
            if (valid_n_s) begin
                {m_tlast_r, m_tdest_r, m_tdata_r} <= rd_word_s;
            end
            err_pulse_r   <= err_s;
            pkt_ok_cnt_r  <= sat_add(pkt_ok_cnt_r, {1'b0, ok_inc_s});
            pkt_err_cnt_r <= sat_add(pkt_err_cnt_r, err_inc_s);
        end
    end

    assign s_tready    = s_tready_r;
    assign m_tvalid    = m_tvalid_r;
    assign m_tdata     = m_tdata_r;
    assign m_tlast     = m_tlast_r;
    assign m_tdest     = m_tdest_r;
    assign err_pulse   = err_pulse_r;
    assign pkt_ok_cnt  = pkt_ok_cnt_r;
    assign pkt_err_cnt = pkt_err_cnt_r;
endmodule

// File: tb/tb_axis_packet_receiver.sv
// Bench for axis_packet_receiver: beat tables with expected error flags, and a scoreboard
// queue of expected output words popped whenever the master port transfers.
`timescale 1ns/1ps
module tb_axis_packet_receiver;
    logic        clk = 1'b0;
    logic        rst_n, s_tvalid, s_tready, s_tlast, m_tvalid, m_tready, m_tlast;
    logic [31:0] s_tdata, m_tdata;
    logic [7:0]  s_tdest, m_tdest;
    logic [3:0]  s_tuser, err_pulse;
    logic [15:0] pkt_ok_cnt, pkt_err_cnt;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] data;
        logic [7:0]  dest;
        logic        first;
        logic        last;
        logic        keep;
        logic [3:0]  exp_err;
    } vec_t;

    logic [40:0] sb[$];   // {last, dest, data}

    axis_packet_receiver #(.DEPTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast),
        .s_tdest(s_tdest), .s_tuser(s_tuser),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
        .m_tdest(m_tdest), .err_pulse(err_pulse),
        .pkt_ok_cnt(pkt_ok_cnt), .pkt_err_cnt(pkt_err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] d, input logic [7:0] dst, input logic f,
                                input logic l, input logic k, input logic [3:0] e);
        vec_t v;
        v.data = d; v.dest = dst; v.first = f; v.last = l; v.keep = k; v.exp_err = e;
        return v;
    endfunction

    // Output monitor: every transfer must match the head of the scoreboard.
    always @(negedge clk) begin
        logic [40:0] w;
        if (rst_n && m_tvalid && m_tready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out actual=%0h required=none", m_tdata);
            end else begin
                w = sb.pop_front();
                check("out_data", 64'(m_tdata), 64'(w[31:0]));
                check("out_dest", 64'(m_tdest), 64'(w[39:32]));
                check("out_last", 64'(m_tlast), 64'(w[40]));
            end
        end
    end

    // Drive one beat from a negedge, wait (bounded) for acceptance, check the error flags.
    task automatic send(input vec_t v);
        int guard;
        guard = 0;
        s_tvalid = 1'b1;
        s_tdata  = v.data;
        s_tdest  = v.dest;
        s_tuser  = {3'b000, v.first};
        s_tlast  = v.last;
        while (!s_tready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout actual=s_tready_low required=accept data=%0h", v.data);
        end else begin
            @(posedge clk);
            #1;
            check("err_pulse", 64'(err_pulse), 64'(v.exp_err));
            if (v.keep) sb.push_back({v.last, v.dest, v.data});
        end
        @(negedge clk);
        s_tvalid = 1'b0;
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while ((sb.size() != 0 || m_tvalid) && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 300) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d_pending required=0", sb.size());
        end
    endtask

    task automatic set_ready(input logic r);
        @(posedge clk);
        #1;
        m_tready = r;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[$];
        tbl.push_back(mk(32'h0700_0000, 8'h07, 1'b1, 1'b1, 1'b1, 4'b0000));
        tbl.push_back(mk(32'h1234_5678, 8'h12, 1'b0, 1'b1, 1'b0, 4'b0001));
        tbl.push_back(mk(32'h2B00_0001, 8'h2B, 1'b1, 1'b0, 1'b1, 4'b0000));
        tbl.push_back(mk(32'h2B00_0002, 8'h2B, 1'b0, 1'b1, 1'b1, 4'b0000));
        tbl.push_back(mk(32'h2200_0001, 8'h22, 1'b1, 1'b0, 1'b0, 4'b0000));
        tbl.push_back(mk(32'h2200_0002, 8'h22, 1'b0, 1'b0, 1'b0, 4'b0000));
        tbl.push_back(mk(32'h2200_0003, 8'h11, 1'b0, 1'b1, 1'b0, 4'b0100));
        tbl.push_back(mk(32'h3C00_0001, 8'h3C, 1'b1, 1'b0, 1'b1, 4'b0000));
        tbl.push_back(mk(32'h3C00_0002, 8'h3C, 1'b0, 1'b1, 1'b1, 4'b0000));
        tbl.push_back(mk(32'h3300_0001, 8'h33, 1'b1, 1'b0, 1'b0, 4'b0000));
        tbl.push_back(mk(32'h4400_0001, 8'h44, 1'b1, 1'b0, 1'b1, 4'b0010));
        tbl.push_back(mk(32'h4400_0002, 8'h44, 1'b0, 1'b1, 1'b1, 4'b0000));
        tbl.push_back(mk(32'h5500_0001, 8'h66, 1'b1, 1'b0, 1'b0, 4'b0100));
        tbl.push_back(mk(32'h5500_0002, 8'h66, 1'b0, 1'b1, 1'b0, 4'b0000));

        rst_n = 1'b0; s_tvalid = 1'b0; s_tdata = 32'h0; s_tdest = 8'h0; s_tuser = 4'h0;
        s_tlast = 1'b0; m_tready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_s_tready", 64'(s_tready), 64'd0);
        check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        check("rst_ok_cnt", 64'(pkt_ok_cnt), 64'd0);
        check("rst_err_cnt", 64'(pkt_err_cnt), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Four-beat packet with latency check after the TLAST edge
        for (int i = 1; i <= 4; i++)
            send(mk(32'hA500_0000 + 32'(i), 8'hA5, (i == 1), (i == 4), 1'b1, 4'b0000));
        check("lat_no_early_valid", 64'(m_tvalid), 64'd0);
        @(negedge clk);
        check("lat_valid", 64'(m_tvalid), 64'd1);
        wait_drain();
        check("t1_ok_cnt", 64'(pkt_ok_cnt), 64'd1);

        for (int i = 0; i < tbl.size(); i++) send(tbl[i]);
        wait_drain();
        check("tbl_ok_cnt", 64'(pkt_ok_cnt), 64'd5);
        check("tbl_err_cnt", 64'(pkt_err_cnt), 64'd4);

        // Overflow on a 10-beat packet, then fill the buffer with two committed packets
        set_ready(1'b0);
        for (int i = 0; i < 10; i++)
            send(mk(32'hB000_0000 + 32'(i), 8'hB0, (i == 0), (i == 9), 1'b0,
                    (i == 8) ? 4'b1000 : 4'b0000));
        check("ovf_err_cnt", 64'(pkt_err_cnt), 64'd5);
        check("ovf_no_output", 64'(m_tvalid), 64'd0);
        for (int p = 1; p <= 2; p++)
            for (int i = 1; i <= 4; i++)
                send(mk({8'hC0 + 8'(p), 24'(i)}, 8'hC0 + 8'(p), (i == 1), (i == 4), 1'b1, 4'b0000));
        check("full_stall", 64'(s_tready), 64'd0);
        check("stall_valid", 64'(m_tvalid), 64'd1);
        check("stall_data", 64'(m_tdata), 64'h0000_0000_C100_0001);
        repeat (3) @(negedge clk);
        check("full_stall_hold", 64'(s_tready), 64'd0);
        check("stall_data_hold", 64'(m_tdata), 64'h0000_0000_C100_0001);
        check("stall_last_hold", 64'(m_tlast), 64'd0);
        set_ready(1'b1);
        wait_drain();
        check("fill_ok_cnt", 64'(pkt_ok_cnt), 64'd7);
        check("ready_after_drain", 64'(s_tready), 64'd1);

        // Asynchronous reset mid-packet while output is valid
        set_ready(1'b0);
        send(mk(32'hD100_0001, 8'hD1, 1'b1, 1'b1, 1'b0, 4'b0000));
        send(mk(32'hD200_0001, 8'hD2, 1'b1, 1'b0, 1'b0, 4'b0000));
        check("pre_rst_valid", 64'(m_tvalid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_m_tvalid", 64'(m_tvalid), 64'd0);
        check("arst_m_tdata", 64'(m_tdata), 64'd0);
        check("arst_m_tlast", 64'(m_tlast), 64'd0);
        check("arst_m_tdest", 64'(m_tdest), 64'd0);
        check("arst_s_tready", 64'(s_tready), 64'd0);
        check("arst_err_pulse", 64'(err_pulse), 64'd0);
        check("arst_ok_cnt", 64'(pkt_ok_cnt), 64'd0);
        check("arst_err_cnt", 64'(pkt_err_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        set_ready(1'b1);
        @(negedge clk);
        send(mk(32'hE500_0001, 8'hE5, 1'b1, 1'b0, 1'b1, 4'b0000));
        send(mk(32'hE500_0002, 8'hE5, 1'b0, 1'b1, 1'b1, 4'b0000));
        wait_drain();
        check("post_rst_ok_cnt", 64'(pkt_ok_cnt), 64'd1);
        check("post_rst_err_cnt", 64'(pkt_err_cnt), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
